// File: rtl/mr_alu_muldiv_pkg.sv
// Shared types for the ALU / iterative mul-div execution slice:
// operation and branch encodings plus the sequencing-state enum.
package mr_alu_muldiv_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLL    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_LT     = 5'd8,
      ALU_LTU    = 5'd9,
      ALU_MUL    = 5'd10,
      ALU_MULH   = 5'd11,
      ALU_MULHSU = 5'd12,
      ALU_MULHU  = 5'd13,
      ALU_DIV    = 5'd14,
      ALU_DIVU   = 5'd15,
      ALU_REM    = 5'd16,
      ALU_REMU   = 5'd17
   } e_aluops;

   typedef enum logic [2:0] {
      BR_NEVER  = 3'd0,
      BR_ALWAYS = 3'd1,
      BR_EQ     = 3'd2,
      BR_NE     = 3'd3,
      BR_LT     = 3'd4,
      BR_LTU    = 3'd5,
      BR_GE     = 3'd6,
      BR_GEU    = 3'd7
   } e_brops;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } e_mdstate;

endpackage

// File: rtl/mr_alu_muldiv_if.sv
// Issue (id_*) and result (ls_*) handshake bundle between decode, execute and load/store.
interface mr_alu_muldiv_if
   import mr_alu_muldiv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REGSEL_BITS = 5,
   parameter int SIDE_W      = 64
);
   logic                   id_valid;
   logic                   id_ready;
   logic [XLEN-1:0]        id_arg1;
   logic [XLEN-1:0]        id_arg2;
   e_aluops                id_aluop;
   e_brops                 id_br_op;
   logic [REGSEL_BITS-1:0] id_dest_reg;
   logic [SIDE_W-1:0]      id_side;

   logic                   ls_valid;
   logic                   ls_ready;
   logic [XLEN-1:0]        ls_dest;
   logic [REGSEL_BITS-1:0] ls_dest_reg;
   logic [SIDE_W-1:0]      ls_side;
   logic                   ls_branch_taken;
   logic                   ls_is_jump;

   modport master (
      output id_valid, id_arg1, id_arg2, id_aluop, id_br_op, id_dest_reg, id_side,
      input  id_ready,
      input  ls_valid, ls_dest, ls_dest_reg, ls_side, ls_branch_taken, ls_is_jump,
      output ls_ready
   );

   modport slave (
      input  id_valid, id_arg1, id_arg2, id_aluop, id_br_op, id_dest_reg, id_side,
      output id_ready,
      output ls_valid, ls_dest, ls_dest_reg, ls_side, ls_branch_taken, ls_is_jump,
      input  ls_ready
   );
endinterface

// File: rtl/mr_alu_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider on operand magnitudes, one bit per cycle.
// done flags the cycle whose final iteration is in flight; result is that iteration's signed-corrected output.
module mr_muldiv_iter
   import mr_alu_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            abort,
   input  logic            start,
   input  e_aluops         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN) + 1;

   logic              busy_r;
   logic [CW-1:0]     cnt_r;
   logic [2*XLEN-1:0] acc_r;
   logic [XLEN-1:0]   b_r;
   logic              neg_r;
   logic              div_r;
   logic              hi_r;

   logic              sa_s, sb_s, hi_s, div_s;
   logic              a_neg_s, b_neg_s;
   logic [XLEN-1:0]   a_abs_s, b_abs_s;
   logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;
   logic [2*XLEN-1:0] acc_next_s, mul_prod_s;
   logic [XLEN-1:0]   half_s;

   // decode signedness, result half and unit selection for the op being started
   always_comb begin
      sa_s  = 1'b0;
      sb_s  = 1'b0;
      hi_s  = 1'b0;
      div_s = 1'b0;
      case (op)
         ALU_MULH:   begin sa_s = 1'b1; sb_s = 1'b1; hi_s = 1'b1; end
         ALU_MULHSU: begin sa_s = 1'b1; hi_s = 1'b1; end
         ALU_MULHU:  begin hi_s = 1'b1; end
         ALU_DIV:    begin sa_s = 1'b1; sb_s = 1'b1; div_s = 1'b1; end
         ALU_DIVU:   begin div_s = 1'b1; end
         ALU_REM:    begin sa_s = 1'b1; sb_s = 1'b1; hi_s = 1'b1; div_s = 1'b1; end
         ALU_REMU:   begin hi_s = 1'b1; div_s = 1'b1; end
         default:    begin sa_s = 1'b0; end
      endcase
      a_neg_s = sa_s & a[XLEN-1];
      b_neg_s = sb_s & b[XLEN-1];
      a_abs_s = a_neg_s ? (-a) : a;
      b_abs_s = b_neg_s ? (-b) : b;
   end

   // one shift-add or shift-subtract step; acc holds {hi, lo} or {remainder, quotient}
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
      div_sh_s   = acc_r[2*XLEN-1:XLEN-1];
      div_diff_s = div_sh_s - {1'b0, b_r};
      if (!div_r) begin
         acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end else if (div_diff_s[XLEN]) begin
         acc_next_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
         acc_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
      mul_prod_s = neg_r ? (-acc_next_s) : acc_next_s;
      half_s     = hi_r ? acc_next_s[2*XLEN-1:XLEN] : acc_next_s[XLEN-1:0];
      if (div_r) begin
         result = neg_r ? (-half_s) : half_s;
      end else if (hi_r) begin
         result = mul_prod_s[2*XLEN-1:XLEN];
      end else begin
         result = mul_prod_s[XLEN-1:0];
      end
      done = busy_r & (cnt_r == CW'(XLEN - 1));
   end

   // operand load on start, then XLEN iterations; abort drops the op
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         cnt_r  <= '0;
         acc_r  <= '0;
         b_r    <= '0;
         neg_r  <= 1'b0;
         div_r  <= 1'b0;
         hi_r   <= 1'b0;
      end else if (abort) begin
         busy_r <= 1'b0;
         cnt_r  <= '0;
      end else if (start) begin
         busy_r <= 1'b1;
         cnt_r  <= '0;
         acc_r  <= {{XLEN{1'b0}}, a_abs_s};
         b_r    <= b_abs_s;
         neg_r  <= (div_s & hi_s) ? a_neg_s : (a_neg_s ^ b_neg_s);
         div_r  <= div_s;
         hi_r   <= hi_s;
      end else if (busy_r) begin
         acc_r <= acc_next_s;
         cnt_r <= cnt_r + CW'(1);
         if (done) begin
            busy_r <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/mr_alu_muldiv.sv
// Execute stage: single-cycle ALU and branch compare, multi-cycle mul/div via mr_muldiv_iter,
// all results delivered through one registered ls_* output slot.
module mr_alu_muldiv
   import mr_alu_muldiv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REGSEL_BITS = 5,
   parameter int SIDE_W      = 64
) (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   mr_alu_muldiv_if.slave bus
);
   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   e_mdstate               state_r;
   logic                   ls_valid_r, ls_taken_r, ls_jump_r;
   logic [XLEN-1:0]        ls_dest_r;
   logic [REGSEL_BITS-1:0] ls_dest_reg_r, h_dest_reg_r;
   logic [SIDE_W-1:0]      ls_side_r, h_side_r;
   logic                   h_taken_r, h_jump_r;

   logic                   id_ready_s, accept_s, fast_s, taken_s, div_zero_s, div_ovf_s;
   logic [XLEN-1:0]        alu_res_s, iter_res_s;
   logic [SHW-1:0]         shamt_s;
   logic                   iter_done_s;

   assign id_ready_s = (state_r == ST_IDLE) & (~ls_valid_r | bus.ls_ready);
   assign accept_s   = bus.id_valid & id_ready_s & ~flush;

   assign bus.id_ready        = id_ready_s;
   assign bus.ls_valid        = ls_valid_r;
   assign bus.ls_dest         = ls_dest_r;
   assign bus.ls_dest_reg     = ls_dest_reg_r;
   assign bus.ls_side         = ls_side_r;
   assign bus.ls_branch_taken = ls_taken_r;
   assign bus.ls_is_jump      = ls_jump_r;

   // single-cycle result, and whether the op bypasses the iterative unit
   always_comb begin
      shamt_s    = bus.id_arg2[SHW-1:0];
      div_zero_s = (bus.id_arg2 == {XLEN{1'b0}});
      div_ovf_s  = (bus.id_arg1 == MOST_NEG) & (bus.id_arg2 == {XLEN{1'b1}});
      fast_s     = 1'b1;
      alu_res_s  = {XLEN{1'b0}};
      case (bus.id_aluop)
         ALU_ADD:  alu_res_s = bus.id_arg1 + bus.id_arg2;
         ALU_SUB:  alu_res_s = bus.id_arg1 - bus.id_arg2;
         ALU_AND:  alu_res_s = bus.id_arg1 & bus.id_arg2;
         ALU_OR:   alu_res_s = bus.id_arg1 | bus.id_arg2;
         ALU_XOR:  alu_res_s = bus.id_arg1 ^ bus.id_arg2;
         ALU_SLL:  alu_res_s = bus.id_arg1 << shamt_s;
         ALU_SRL:  alu_res_s = bus.id_arg1 >> shamt_s;
         ALU_SRA:  alu_res_s = XLEN'($signed(bus.id_arg1) >>> shamt_s);
         ALU_LT:   alu_res_s = {{(XLEN-1){1'b0}}, $signed(bus.id_arg1) < $signed(bus.id_arg2)};
         ALU_LTU:  alu_res_s = {{(XLEN-1){1'b0}}, bus.id_arg1 < bus.id_arg2};
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: fast_s = 1'b0;
         // divide-by-zero and most-negative/-1 have fixed answers and skip iteration
         ALU_DIV: begin
            fast_s    = div_zero_s | div_ovf_s;
            alu_res_s = div_zero_s ? {XLEN{1'b1}} : bus.id_arg1;
         end
         ALU_DIVU: begin
            fast_s    = div_zero_s;
            alu_res_s = {XLEN{1'b1}};
         end
         ALU_REM: begin
            fast_s    = div_zero_s | div_ovf_s;
            alu_res_s = div_zero_s ? bus.id_arg1 : {XLEN{1'b0}};
         end
         ALU_REMU: begin
            fast_s    = div_zero_s;
            alu_res_s = bus.id_arg1;
         end
         default:  alu_res_s = {XLEN{1'b0}};
      endcase
   end

   // branch condition on the issuing operands
   always_comb begin
      case (bus.id_br_op)
         BR_NEVER:  taken_s = 1'b0;
         BR_ALWAYS: taken_s = 1'b1;
         BR_EQ:     taken_s = (bus.id_arg1 == bus.id_arg2);
         BR_NE:     taken_s = (bus.id_arg1 != bus.id_arg2);
         BR_LT:     taken_s = ($signed(bus.id_arg1) < $signed(bus.id_arg2));
         BR_LTU:    taken_s = (bus.id_arg1 < bus.id_arg2);
         BR_GE:     taken_s = ($signed(bus.id_arg1) >= $signed(bus.id_arg2));
         BR_GEU:    taken_s = (bus.id_arg1 >= bus.id_arg2);
         default:   taken_s = 1'b0;
      endcase
   end

   mr_muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .abort  (flush),
      .start  (accept_s & ~fast_s),
      .op     (bus.id_aluop),
      .a      (bus.id_arg1),
      .b      (bus.id_arg2),
      .done   (iter_done_s),
      .result (iter_res_s)
   );

   // sequencing FSM and the registered output slot
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         ls_valid_r    <= 1'b0;
         ls_dest_r     <= '0;
         ls_dest_reg_r <= '0;
         ls_side_r     <= '0;
         ls_taken_r    <= 1'b0;
         ls_jump_r     <= 1'b0;
         h_dest_reg_r  <= '0;
         h_side_r      <= '0;
         h_taken_r     <= 1'b0;
         h_jump_r      <= 1'b0;
      end else if (flush) begin
         state_r    <= ST_IDLE;
         ls_valid_r <= 1'b0;
      end else begin
         if (bus.ls_ready) begin
            ls_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (accept_s && fast_s) begin
                  ls_valid_r    <= 1'b1;
                  ls_dest_r     <= alu_res_s;
                  ls_dest_reg_r <= bus.id_dest_reg;
                  ls_side_r     <= bus.id_side;
                  ls_taken_r    <= taken_s;
                  ls_jump_r     <= (bus.id_br_op == BR_ALWAYS);
               end else if (accept_s) begin
                  state_r      <= ST_BUSY;
                  h_dest_reg_r <= bus.id_dest_reg;
                  h_side_r     <= bus.id_side;
                  h_taken_r    <= taken_s;
                  h_jump_r     <= (bus.id_br_op == BR_ALWAYS);
               end
            end
            // the slot is always free here: acceptance required it, and nothing loads meanwhile
            ST_BUSY: begin
               if (iter_done_s) begin
                  state_r       <= ST_DONE;
                  ls_valid_r    <= 1'b1;
                  ls_dest_r     <= iter_res_s;
                  ls_dest_reg_r <= h_dest_reg_r;
                  ls_side_r     <= h_side_r;
                  ls_taken_r    <= h_taken_r;
                  ls_jump_r     <= h_jump_r;
               end
            end
            ST_DONE: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mr_alu_muldiv.sv
// Directed self-checking bench for mr_alu_muldiv (XLEN=32).
module tb_mr_alu_muldiv;
   import mr_alu_muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n, bad;

   mr_alu_muldiv_if #(.XLEN(32), .REGSEL_BITS(5), .SIDE_W(64)) bus ();

   mr_alu_muldiv #(.XLEN(32), .REGSEL_BITS(5), .SIDE_W(64)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      e_aluops     op;
      e_brops      br;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        tk;
      logic        jp;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [0:NV-1] = '{
      '{ALU_SUB,  BR_NEVER,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0},
      '{ALU_AND,  BR_NEVER,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0},
      '{ALU_OR,   BR_NEVER,  32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0},
      '{ALU_XOR,  BR_NEVER,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0},
      '{ALU_SLL,  BR_NEVER,  32'd1,         32'h0000_0021, 32'd2,         1'b0, 1'b0},
      '{ALU_SRL,  BR_NEVER,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0},
      '{ALU_SRA,  BR_NEVER,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0},
      '{ALU_LT,   BR_NEVER,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0},
      '{ALU_LTU,  BR_NEVER,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0},
      '{ALU_DIV,  BR_NEVER,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0},
      '{ALU_REM,  BR_NEVER,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0},
      '{ALU_DIVU, BR_NEVER,  32'd10,        32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0},
      '{ALU_REM,  BR_NEVER,  32'd10,        32'd0,         32'd10,        1'b0, 1'b0},
      '{ALU_DIV,  BR_NEVER,  32'd10,        32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0},
      '{ALU_ADD,  BR_EQ,     32'd3,         32'd3,         32'd6,         1'b1, 1'b0},
      '{ALU_ADD,  BR_LTU,    32'd1,         32'd2,         32'd3,         1'b1, 1'b0},
      '{ALU_ADD,  BR_GE,     32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0},
      '{ALU_ADD,  BR_ALWAYS, 32'd0,         32'd0,         32'd0,         1'b1, 1'b1},
      '{ALU_ADD,  BR_NE,     32'd4,         32'd4,         32'd8,         1'b0, 1'b0},
      '{ALU_ADD,  BR_LT,     32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0},
      '{ALU_ADD,  BR_GEU,    32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0}
   };

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input e_aluops op, input e_brops br, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dreg, input logic [63:0] side);
      bus.id_valid    = 1'b1;
      bus.id_aluop    = op;
      bus.id_br_op    = br;
      bus.id_arg1     = a;
      bus.id_arg2     = b;
      bus.id_dest_reg = dreg;
      bus.id_side     = side;
   endtask

   task automatic run_multi(input string tag, input e_aluops op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
      drive(op, BR_NEVER, a, b, 5'd9, 64'h5A5A);
      tick();
      bus.id_valid = 1'b0;
      n = 1;
      while (bus.ls_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'd33);
      check(tag, {32'd0, bus.ls_dest}, {32'd0, exp});
      tick();
   endtask

   initial begin
      bus.id_valid = 1'b0;
      bus.ls_ready = 1'b1;
      drive(ALU_ADD, BR_NEVER, 32'd0, 32'd0, 5'd0, 64'd0);
      bus.id_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst_valid", {63'd0, bus.ls_valid}, 64'd0);
      check("rst_dest", {32'd0, bus.ls_dest}, 64'd0);
      check("rst_dreg", {59'd0, bus.ls_dest_reg}, 64'd0);
      check("rst_side", bus.ls_side, 64'd0);
      check("rst_br", {62'd0, bus.ls_branch_taken, bus.ls_is_jump}, 64'd0);
      check("rst_ready", {63'd0, bus.id_ready}, 64'd1);

      // ADD 5+7 with fields carried alongside
      drive(ALU_ADD, BR_NEVER, 32'd5, 32'd7, 5'd3, 64'hDEAD_BEEF_0000_ABCD);
      tick();
      bus.id_valid = 1'b0;
      check("add_valid", {63'd0, bus.ls_valid}, 64'd1);
      check("add_dest", {32'd0, bus.ls_dest}, 64'd12);
      check("add_dreg", {59'd0, bus.ls_dest_reg}, 64'd3);
      check("add_side", bus.ls_side, 64'hDEAD_BEEF_0000_ABCD);
      tick();
      check("add_retire", {63'd0, bus.ls_valid}, 64'd0);

      // back-to-back single-cycle / fast-path / branch vectors
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].op, vecs[i].br, vecs[i].a, vecs[i].b, 5'(i), {32'hC0DE, 32'(i)});
         #1;
         check($sformatf("v%0d_ready", i), {63'd0, bus.id_ready}, 64'd1);
         tick();
         check($sformatf("v%0d_valid", i), {63'd0, bus.ls_valid}, 64'd1);
         check($sformatf("v%0d_dest", i), {32'd0, bus.ls_dest}, {32'd0, vecs[i].exp});
         check($sformatf("v%0d_br", i), {62'd0, bus.ls_branch_taken, bus.ls_is_jump},
               {62'd0, vecs[i].tk, vecs[i].jp});
         check($sformatf("v%0d_tag", i), {27'd0, bus.ls_dest_reg, bus.ls_side[31:0]},
               {27'd0, 5'(i), 32'(i)});
      end
      bus.id_valid = 1'b0;
      tick();
      check("b2b_drain", {63'd0, bus.ls_valid}, 64'd0);

      // MULHU all-ones: result at cycle 33, id_ready low throughout
      drive(ALU_MULHU, BR_ALWAYS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 64'h1234_5678_9ABC_DEF0);
      tick();
      bus.id_valid = 1'b0;
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         if (bus.id_ready !== 1'b0) bad++;
         if (k < 33 && bus.ls_valid !== 1'b0) bad++;
         if (k < 33) tick();
      end
      check("mulhu_busy", 64'(bad), 64'd0);
      check("mulhu_valid", {63'd0, bus.ls_valid}, 64'd1);
      check("mulhu_dest", {32'd0, bus.ls_dest}, 64'hFFFF_FFFE);
      check("mulhu_dreg", {59'd0, bus.ls_dest_reg}, 64'd17);
      check("mulhu_side", bus.ls_side, 64'h1234_5678_9ABC_DEF0);
      check("mulhu_jump", {62'd0, bus.ls_branch_taken, bus.ls_is_jump}, 64'd3);
      tick();
      check("mulhu_idle", {62'd0, bus.id_ready, bus.ls_valid}, 64'd2);

      run_multi("mul", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_multi("mulh_m1", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      run_multi("mulh_mn", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_multi("mulh_neg", ALU_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
      run_multi("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_multi("mulhu", ALU_MULHU, 32'h8000_0000, 32'd4, 32'd2);
      run_multi("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_multi("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_multi("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);
      run_multi("remu", ALU_REMU, 32'd100, 32'd7, 32'd2);
      run_multi("div_nd", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_multi("rem_nd", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);

      // SUB 9-4 stalled three cycles while a following ADD waits
      bus.ls_ready = 1'b0;
      drive(ALU_SUB, BR_NEVER, 32'd9, 32'd4, 5'd1, 64'd0);
      #1;
      check("stall_rdy0", {63'd0, bus.id_ready}, 64'd1);
      tick();
      drive(ALU_ADD, BR_NEVER, 32'd1, 32'd1, 5'd2, 64'd0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("stall%0d", k), {30'd0, bus.ls_valid, bus.id_ready, bus.ls_dest},
               {30'd0, 1'b1, 1'b0, 32'd5});
         tick();
      end
      bus.ls_ready = 1'b1;
      #1;
      check("stall_rel", {30'd0, bus.ls_valid, bus.id_ready, bus.ls_dest},
            {30'd0, 1'b1, 1'b1, 32'd5});
      tick();
      bus.id_valid = 1'b0;
      check("stall_next", {31'd0, bus.ls_valid, bus.ls_dest}, {31'd0, 1'b1, 32'd2});
      tick();
      check("stall_drain", {63'd0, bus.ls_valid}, 64'd0);

      // flush DIVU 100/7 at cycle 10
      drive(ALU_DIVU, BR_NEVER, 32'd100, 32'd7, 5'd4, 64'd0);
      tick();
      bus.id_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_idle", {63'd0, bus.id_ready}, 64'd1);
      bad = 0;
      repeat (40) begin
         tick();
         if (bus.ls_valid !== 1'b0) bad++;
      end
      check("flush_drop", 64'(bad), 64'd0);

      // op offered during flush is not taken
      drive(ALU_ADD, BR_NEVER, 32'd50, 32'd50, 5'd5, 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.id_valid = 1'b0;
      check("flush_noacc", {63'd0, bus.ls_valid}, 64'd0);
      tick();
      check("flush_noacc2", {63'd0, bus.ls_valid}, 64'd0);
      drive(ALU_ADD, BR_NEVER, 32'd1, 32'd1, 5'd6, 64'd0);
      tick();
      bus.id_valid = 1'b0;
      check("post_flush", {31'd0, bus.ls_valid, bus.ls_dest}, {31'd0, 1'b1, 32'd2});
      tick();

      // reset mid-BUSY abandons the op and clears the output slot
      drive(ALU_MUL, BR_ALWAYS, 32'd3, 32'd5, 5'd7, 64'hFFFF);
      tick();
      bus.id_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      flush = 1'b1;
      tick();
      rst = 1'b0;
      flush = 1'b0;
      check("rstb_out", {30'd0, bus.ls_valid, bus.id_ready, bus.ls_dest}, {30'd0, 1'b0, 1'b1, 32'd0});
      check("rstb_fields", {bus.ls_side[56:0], bus.ls_dest_reg, bus.ls_branch_taken, bus.ls_is_jump},
            64'd0);
      bad = 0;
      repeat (40) begin
         tick();
         if (bus.ls_valid !== 1'b0) bad++;
      end
      check("rstb_drop", 64'(bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mr_alu_muldiv.md
MR_ALU_MULDIV -- requirements
Module: mr_alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter REGSEL_BITS, default 5: destination register select width.
REQ-003 Parameter SIDE_W, default 64: width of the opaque sideband passed through unchanged (memop, size, signed, payload, inst id, prediction).
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  abort any in-flight op and drop the output.
REQ-007 id_valid  in  1  upstream op valid.
REQ-008 id_ready  out  1  op accepted this cycle when id_valid & id_ready.
REQ-009 id_arg1, id_arg2  in  XLEN  operands.
REQ-010 id_aluop  in  e_aluops  base ALU ops plus MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-011 id_br_op  in  e_brops  branch compare op.
REQ-012 id_dest_reg  in  REGSEL_BITS  destination register.
REQ-013 id_side  in  SIDE_W  sideband.
REQ-014 ls_valid  out  1  result valid, registered.
REQ-015 ls_ready  in  1  downstream accepts.
REQ-016 ls_dest  out  XLEN  result.
REQ-017 ls_dest_reg  out  REGSEL_BITS; ls_side  out  SIDE_W; ls_branch_taken  out  1; ls_is_jump  out  1.

Function
REQ-018 Single-cycle ops (ADD, SUB, AND, OR, XOR, shifts, LT, LTU) SHALL produce ls_valid on the cycle after acceptance; shift amount SHALL be arg2[log2(XLEN)-1:0].
REQ-019 Branch evaluation SHALL match NEVER/ALWAYS/EQ/NE/LT/LTU/GE/GEU semantics; ls_is_jump = (br_op==ALWAYS); both registered alongside ls_dest.
REQ-020 MUL* and DIV/REM* SHALL run on an iterative radix-2 unit: one bit per cycle, XLEN iterations, ls_valid asserted XLEN+1 cycles after acceptance.
REQ-021 MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN signed*signed / signed*unsigned / unsigned*unsigned product.
REQ-022 Divide by zero: quotient all-ones, remainder = arg1; signed overflow (most negative / -1): quotient = arg1, remainder 0; both SHALL take the fast path, with ls_valid on the cycle after acceptance.
REQ-023 FSM states IDLE, BUSY, DONE: IDLE->BUSY on accepting a multi-cycle op; BUSY->DONE when the iteration count reaches XLEN; DONE->IDLE when the output register is loaded.
REQ-024 id_ready = (state==IDLE) & (~ls_valid | ls_ready); deasserted throughout BUSY and DONE.
REQ-025 ls_valid and all ls_* outputs SHALL hold stable while ls_valid & ~ls_ready; no result is ever dropped or duplicated.
REQ-026 Back-to-back single-cycle ops with ls_ready held high SHALL sustain one op per cycle.
REQ-027 flush SHALL, on the next edge, clear ls_valid, return the FSM to IDLE, and discard the in-flight op; an id_valid in the flush cycle SHALL NOT be accepted.
REQ-028 dest_reg, sideband and branch fields SHALL be captured at acceptance and emitted with that op's result.

Reset
REQ-029 On rst: ls_valid=0, FSM=IDLE, iteration counter=0; ls_dest, ls_dest_reg, ls_side, ls_branch_taken and ls_is_jump SHALL be 0.
REQ-030 rst asserted mid-BUSY SHALL abandon the op with no output; rst has priority over flush.

Structure
REQ-031 The extended e_aluops enum, e_brops, and the FSM state enum SHALL live in the shared config package.
REQ-032 The iterative multiply/divide datapath SHALL be a sub-module mr_muldiv_iter with start/done handshake; the ALU, branch compare and output register stay in mr_alu_muldiv.

Verification
REQ-033 ADD 5+7, ls_ready=1 -> ls_valid one cycle later, ls_dest=12.
REQ-034 MULHU 0xFFFFFFFF*0xFFFFFFFF -> ls_dest=0xFFFFFFFE at cycle 33; id_ready low cycles 1-33.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 next cycle; DIVU 10/0 -> 0xFFFFFFFF; REM 10/0 -> 10.
REQ-036 SUB 9-4 with ls_ready=0 for 3 cycles -> ls_valid and ls_dest=5 stable, retired once ls_ready rises.
REQ-037 flush at cycle 10 of DIVU 100/7 -> no ls_valid; a following ADD 1+1 completes as 2.
REQ-038 BEQ 3,3 and BLTU 1,2 -> ls_branch_taken=1; BGE -1,0 -> 0.
